// File: rtl/bank_burst_pkg.sv
// -----------------------------------------------------------------------------
// bank_burst_pkg
// Shared types and helpers for the bank burst master.
//   state_e : burst controller states (IDLE, ISSUE, DRAIN, DONE)
//   bank_w  : width of a bank index for a given bank count (minimum 1 bit)
// -----------------------------------------------------------------------------
package bank_burst_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Bank index width; a single-bank slot still carries a 1-bit index.
   function automatic int bank_w(input int num_banks);
      if (num_banks > 1) begin
         return $clog2(num_banks);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/bank_burst_master_chk.sv
// -----------------------------------------------------------------------------
// bank_burst_master_chk
// Protocol checker for the bank burst master (simulation only, no logic).
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   rsp_valid         read return strobe from the slot
//   outstanding_zero  no read command is awaiting its return
//   fifo_push         read buffer push request
//   fifo_pop          read buffer pop request
//   fifo_full         read buffer full flag
// -----------------------------------------------------------------------------
module bank_burst_master_chk (
   input logic clk,
   input logic rstn,
   input logic rsp_valid,
   input logic outstanding_zero,
   input logic fifo_push,
   input logic fifo_pop,
   input logic fifo_full
);

   // A read return with nothing outstanding is dropped by the master.
   a_rsp_expected : assert property (@(posedge clk) disable iff (!rstn)
      rsp_valid |-> !outstanding_zero);

   // Credit accounting must never push into a full buffer without a pop.
   a_fifo_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
      (fifo_push && fifo_full) |-> fifo_pop);

endmodule

// File: rtl/bank_burst_rd_fifo.sv
// -----------------------------------------------------------------------------
// bank_burst_rd_fifo
// Synchronous first-word-fall-through FIFO holding read returns until the
// consumer takes them. The head word is visible whenever empty is low.
// Push and pop in the same cycle are accepted, including when full.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   push, push_data  write side (ignored when full and not popping)
//   pop              read side (ignored when empty)
//   head             current head word
//   empty, full      occupancy flags
//   count            number of stored words (0..DEPTH)
// -----------------------------------------------------------------------------
module bank_burst_rd_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 32,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign empty     = (count_r == '0);
   assign full      = (count_r == CNT_W'(DEPTH));
   assign pop_ok_s  = pop && !empty;
   // A pop in the same cycle frees the slot the push needs.
   assign push_ok_s = push && (!full || pop_ok_s);
   assign head      = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Pointer and occupancy tracking; power-of-two depth lets pointers wrap freely.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents are only observed through count, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

endmodule

// File: rtl/bank_burst_master.sv
// -----------------------------------------------------------------------------
// bank_burst_master
// Initiator for one bank RAM bus slot. A descriptor (op, bank, addr, len)
// becomes a stream of word commands. Writes forward a valid/ready write
// stream straight onto the command channel; reads are credit-limited so
// every return has a guaranteed slot in the read buffer, which is presented
// as a first-word-fall-through valid/ready stream.
// Configuration macro: BANK_BURST_INTERLEAVE_EN
//   defined   : bank = (base_bank + i) mod NUM_BANKS, address steps each
//               time the bank index wraps to 0
//   undefined : bank fixed at base_bank, address steps every word
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   start, op_write, base_bank,
//   base_addr, len                 descriptor, sampled in IDLE only
//   busy, done                     status; done is a one-cycle pulse
//   wr_valid/wr_ready/wr_data      write data stream (sink)
//   rd_valid/rd_ready/rd_data      read data stream (source)
//   cmd_valid/cmd_ready, cmd_we,
//   cmd_bank, cmd_addr, cmd_wdata  slot command channel
//   rsp_valid, rsp_data            in-order read returns, no backpressure
// -----------------------------------------------------------------------------
module bank_burst_master
   import bank_burst_pkg::*;
#(
   parameter  int NUM_BANKS     = 5,
   parameter  int ADDR_WIDTH    = 9,
   parameter  int DATA_WIDTH    = 32,
   parameter  int LEN_WIDTH     = 12,
   parameter  int RD_FIFO_DEPTH = 8,
   localparam int BANK_W        = bank_w(NUM_BANKS)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  op_write,
   input  logic [BANK_W-1:0]     base_bank,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic                  cmd_we,
   output logic [BANK_W-1:0]     cmd_bank,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   output logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic                  rsp_valid,
   input  logic [DATA_WIDTH-1:0] rsp_data
);

   localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;
   localparam int CRD_W = CNT_W + 1;

   state_e                state_r;
   state_e                state_s;
   logic                  op_write_r;
   logic [BANK_W-1:0]     bank_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [LEN_WIDTH-1:0]  cmd_left_r;
   logic [LEN_WIDTH-1:0]  pop_left_r;
   logic [CNT_W-1:0]      outstanding_r;

   logic [CNT_W-1:0]      fifo_count_s;
   logic                  fifo_empty_s;
   logic                  fifo_full_s;
   logic [CRD_W-1:0]      credits_s;
   logic                  credit_ok_s;
   logic                  cmd_valid_s;
   logic                  wr_ready_s;
   logic                  cmd_fire_s;
   logic                  rsp_ok_s;
   logic                  pop_fire_s;
   logic                  last_cmd_s;
   logic                  last_pop_s;
   logic [BANK_W-1:0]     bank_nxt_s;
   logic [ADDR_WIDTH-1:0] addr_nxt_s;

   // Words already requested but not yet consumed; capped at the buffer depth.
   assign credits_s   = CRD_W'(outstanding_r) + CRD_W'(fifo_count_s);
   assign credit_ok_s = (credits_s < CRD_W'(RD_FIFO_DEPTH));
   // Returns with nothing outstanding are dropped instead of buffered.
   assign rsp_ok_s    = rsp_valid && (outstanding_r != '0);
   assign cmd_fire_s  = cmd_valid_s && cmd_ready;
   assign pop_fire_s  = !fifo_empty_s && rd_ready;
   assign last_cmd_s  = (cmd_left_r == LEN_WIDTH'(1));
   assign last_pop_s  = (pop_left_r == LEN_WIDTH'(1));

   // Next-state and command/write-stream handshake decode.
   always_comb begin
      state_s     = state_r;
      cmd_valid_s = 1'b0;
      wr_ready_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_s = DONE;
               end else begin
                  state_s = ISSUE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (op_write_r) begin
               cmd_valid_s = wr_valid;
               wr_ready_s  = cmd_ready;
            end else begin
               cmd_valid_s = credit_ok_s;
               wr_ready_s  = 1'b0;
            end
            if (cmd_valid_s && cmd_ready && last_cmd_s) begin
               if (op_write_r) begin
                  state_s = DONE;
               end else begin
                  state_s = DRAIN;
               end
            end else begin
               state_s = ISSUE;
            end
         end
         DRAIN: begin
            if (pop_fire_s && last_pop_s) begin
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Position of the word after the current one.
   always_comb begin
      bank_nxt_s = bank_r;
      addr_nxt_s = addr_r;
`ifdef BANK_BURST_INTERLEAVE_EN
      if (bank_r >= BANK_W'(NUM_BANKS - 1)) begin
         bank_nxt_s = '0;
         addr_nxt_s = addr_r + ADDR_WIDTH'(1);
      end else begin
         bank_nxt_s = bank_r + BANK_W'(1);
         addr_nxt_s = addr_r;
      end
`else
      bank_nxt_s = bank_r;
      addr_nxt_s = addr_r + ADDR_WIDTH'(1);
`endif
   end

   // Controller state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Descriptor capture, address walk and per-burst word counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_write_r <= 1'b0;
         bank_r     <= '0;
         addr_r     <= '0;
         cmd_left_r <= '0;
         pop_left_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  op_write_r <= op_write;
                  bank_r     <= base_bank;
                  addr_r     <= base_addr;
                  cmd_left_r <= len;
                  pop_left_r <= op_write ? '0 : len;
               end
            end
            ISSUE: begin
               if (cmd_fire_s) begin
                  bank_r     <= bank_nxt_s;
                  addr_r     <= addr_nxt_s;
                  cmd_left_r <= cmd_left_r - LEN_WIDTH'(1);
               end
               if (pop_fire_s && (pop_left_r != '0)) begin
                  pop_left_r <= pop_left_r - LEN_WIDTH'(1);
               end
            end
            DRAIN: begin
               if (pop_fire_s && (pop_left_r != '0)) begin
                  pop_left_r <= pop_left_r - LEN_WIDTH'(1);
               end
            end
            default: begin
               cmd_left_r <= cmd_left_r;
            end
         endcase
      end
   end

   // Reads in flight; an accept and a return in the same cycle cancel out.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outstanding_r <= '0;
      end else begin
         case ({cmd_fire_s && !op_write_r, rsp_ok_s})
            2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
            2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
            default: outstanding_r <= outstanding_r;
         endcase
      end
   end

   bank_burst_rd_fifo #(
      .DEPTH (RD_FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_rd_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (rsp_ok_s),
      .push_data (rsp_data),
      .pop       (pop_fire_s),
      .head      (rd_data),
      .empty     (fifo_empty_s),
      .full      (fifo_full_s),
      .count     (fifo_count_s)
   );

   bank_burst_master_chk u_chk (
      .clk              (clk),
      .rstn             (rstn),
      .rsp_valid        (rsp_valid),
      .outstanding_zero (outstanding_r == '0),
      .fifo_push        (rsp_ok_s),
      .fifo_pop         (pop_fire_s),
      .fifo_full        (fifo_full_s)
   );

   assign busy      = (state_r != IDLE);
   assign done      = (state_r == DONE);
   assign cmd_valid = cmd_valid_s;
   assign wr_ready  = wr_ready_s;
   assign cmd_we    = op_write_r;
   assign cmd_bank  = bank_r;
   assign cmd_addr  = addr_r;
   assign cmd_wdata = wr_data;
   assign rd_valid  = !fifo_empty_s;

endmodule

// File: tb/tb_bank_burst_master.sv
// -----------------------------------------------------------------------------
// tb_bank_burst_master
// Scoreboard bench for bank_burst_master. Expected commands and read words
// are queued when a descriptor is accepted and compared as the DUT moves
// them. Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_bank_burst_master;
   import bank_burst_pkg::*;

   localparam int NB = 5;
   localparam int AW = 9;
   localparam int DW = 32;
   localparam int LW = 12;
   localparam int DEPTH = 8;
   localparam int BW = 3;

   typedef struct packed {
      logic          we;
      logic [BW-1:0] bank;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic [31:0]   due;
      logic [DW-1:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic rstn;
   logic start, op_write;
   logic [BW-1:0] base_bank;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] len;
   logic busy, done;
   logic wr_valid, wr_ready;
   logic [DW-1:0] wr_data;
   logic rd_valid, rd_ready;
   logic [DW-1:0] rd_data;
   logic cmd_valid, cmd_ready, cmd_we;
   logic [BW-1:0] cmd_bank;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic rsp_valid;
   logic [DW-1:0] rsp_data;

   bank_burst_master dut (
      .clk(clk), .rstn(rstn), .start(start), .op_write(op_write),
      .base_bank(base_bank), .base_addr(base_addr), .len(len),
      .busy(busy), .done(done),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   cmd_t          cmd_q [$];
   logic [DW-1:0] rd_q [$];
   rsp_t          rsp_q [$];
   logic [DW-1:0] wr_src [$];
   logic [AW-1:0] acc_addr [$];
   logic [BW-1:0] acc_bank [$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int n_cmd = 0;
   int n_done = 0;
   int cmd_left = 0;
   int pop_left = 0;
   logic burst_we = 1'b0;
   logic exp_done = 1'b0;
   logic hold = 1'b0;
   logic wr_taken = 1'b0;
   cmd_t held;
   logic [15:0] rsp_seq = 16'd0;
   logic [15:0] exp_seq = 16'd0;
   logic cr_rand = 1'b0;
   logic wv_rand = 1'b0;
   logic rr_en = 1'b1;
   logic start_req = 1'b0;
   logic req_we = 1'b0;
   logic [BW-1:0] req_bank = '0;
   logic [AW-1:0] req_addr = '0;
   logic [LW-1:0] req_len = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Queue the commands and read words a descriptor must produce.
   task automatic model_burst(input logic we, input logic [BW-1:0] b0,
                              input logic [AW-1:0] a0, input logic [LW-1:0] l);
      cmd_t e;
      logic [BW-1:0] b;
      logic [AW-1:0] a;
      b = b0;
      a = a0;
      for (int i = 0; i < int'(l); i++) begin
         e.we    = we;
         e.bank  = b;
         e.addr  = a;
         e.wdata = we ? $urandom : 32'd0;
         cmd_q.push_back(e);
         if (we) begin
            wr_src.push_back(e.wdata);
         end else begin
            rd_q.push_back({exp_seq, 1'b0, b, 3'b000, a});
            exp_seq = exp_seq + 16'd1;
         end
`ifdef BANK_BURST_INTERLEAVE_EN
         if (b == BW'(NB - 1)) begin
            b = '0;
            a = a + AW'(1);
         end else begin
            b = b + BW'(1);
         end
`else
         a = a + AW'(1);
`endif
      end
   endtask

   // One clock: drive inputs, sample outputs, update the scoreboard.
   task automatic cycle();
      cmd_t e;
      rsp_t r;
      logic fin;
      @(negedge clk);
      cyc++;
      if (rsp_q.size() != 0 && rsp_q[0].due == 32'(cyc)) begin
         rsp_valid = 1'b1;
         rsp_data  = rsp_q[0].data;
         void'(rsp_q.pop_front());
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = '0;
      end
      cmd_ready = cr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      rd_ready  = rr_en;
      if (wr_src.size() != 0) begin
         if (!wr_valid || wr_taken) begin
            wr_valid = wv_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
         end
         wr_data = wr_src[0];
      end else begin
         wr_valid = 1'b0;
      end
      wr_taken  = 1'b0;
      start     = start_req;
      op_write  = req_we;
      base_bank = req_bank;
      base_addr = req_addr;
      len       = req_len;
      start_req = 1'b0;
      #1;
      fin = 1'b0;
      check("done", 64'(done), 64'(exp_done));
      if (done) n_done++;
      if (busy && burst_we && cmd_left > 0) begin
         check("wr_ready", 64'(wr_ready), 64'(cmd_ready));
      end else begin
         check("wr_ready_idle", 64'(wr_ready), 64'(0));
      end
      if (hold) begin
         check("cmd_hold_valid", 64'(cmd_valid), 64'(1));
         check("cmd_hold_fields", 64'({cmd_we, cmd_bank, cmd_addr}),
               64'({held.we, held.bank, held.addr}));
         if (held.we) check("cmd_hold_wdata", 64'(cmd_wdata), 64'(held.wdata));
      end
      hold = 1'b0;
      if (cmd_valid) begin
         if (cmd_q.size() == 0) begin
            check("cmd_spurious", 64'(1), 64'(0));
         end else if (cmd_ready) begin
            e = cmd_q.pop_front();
            check("cmd_we", 64'(cmd_we), 64'(e.we));
            check("cmd_bank", 64'(cmd_bank), 64'(e.bank));
            check("cmd_addr", 64'(cmd_addr), 64'(e.addr));
            if (e.we) check("cmd_wdata", 64'(cmd_wdata), 64'(e.wdata));
            n_cmd++;
            acc_addr.push_back(cmd_addr);
            acc_bank.push_back(cmd_bank);
            if (!cmd_we) begin
               r.due  = 32'(cyc + 2);
               r.data = {rsp_seq, 1'b0, cmd_bank, 3'b000, cmd_addr};
               rsp_q.push_back(r);
               rsp_seq = rsp_seq + 16'd1;
            end else begin
               if (wr_src.size() != 0) void'(wr_src.pop_front());
               wr_taken = 1'b1;
            end
            cmd_left--;
            if (burst_we && cmd_left == 0) fin = 1'b1;
         end else begin
            hold = 1'b1;
            held.we = cmd_we;
            held.bank = cmd_bank;
            held.addr = cmd_addr;
            held.wdata = cmd_wdata;
         end
      end
      if (rd_valid && rd_ready) begin
         if (rd_q.size() == 0) begin
            check("rd_spurious", 64'(1), 64'(0));
         end else begin
            check("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
            pop_left--;
            if (pop_left == 0) fin = 1'b1;
         end
      end
      if (start && !busy) begin
         burst_we = op_write;
         cmd_left = int'(len);
         pop_left = op_write ? 0 : int'(len);
         model_burst(op_write, base_bank, base_addr, len);
         if (len == '0) fin = 1'b1;
      end
      exp_done = fin;
   endtask

   task automatic launch(input logic we, input logic [BW-1:0] b,
                         input logic [AW-1:0] a, input logic [LW-1:0] l);
      req_we = we;
      req_bank = b;
      req_addr = a;
      req_len = l;
      start_req = 1'b1;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int k = 0;
      while (n_done == d0 && k < budget) begin
         cycle();
         k++;
      end
      check("burst_timeout", 64'(n_done != d0), 64'(1));
      cycle();
      check("cmd_q_empty", 64'(cmd_q.size()), 64'(0));
      check("rd_q_empty", 64'(rd_q.size()), 64'(0));
   endtask

   task automatic run_burst(input logic we, input logic [BW-1:0] b,
                            input logic [AW-1:0] a, input logic [LW-1:0] l);
      int d0 = n_done;
      launch(we, b, a, l);
      wait_done(d0, 300);
   endtask

   initial begin
      int n0, d0;
      logic [AW-1:0] ea [4];
      logic [BW-1:0] eb [4];
      rstn = 1'b0; start = 1'b0; op_write = 1'b0; base_bank = '0; base_addr = '0;
      len = '0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; cmd_ready = 1'b0;
      rsp_valid = 1'b0; rsp_data = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
      check("rst_rd_valid", 64'(rd_valid), 64'(0));
      check("rst_wr_ready", 64'(wr_ready), 64'(0));
      rstn = 1'b1;
      cycle();

      // 1: read len 4 from bank 2, addr 0x10
      acc_addr.delete(); acc_bank.delete();
      run_burst(1'b0, 3'd2, 9'h010, 12'd4);
`ifdef BANK_BURST_INTERLEAVE_EN
      ea = '{9'h010, 9'h010, 9'h010, 9'h011}; eb = '{3'd2, 3'd3, 3'd4, 3'd0};
`else
      ea = '{9'h010, 9'h011, 9'h012, 9'h013}; eb = '{3'd2, 3'd2, 3'd2, 3'd2};
`endif
      check("t1_ncmd", 64'(acc_addr.size()), 64'(4));
      for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
         check("t1_addr", 64'(acc_addr[i]), 64'(ea[i]));
         check("t1_bank", 64'(acc_bank[i]), 64'(eb[i]));
      end

      // 2: read len 20 against a stalled consumer, then release
      n0 = n_cmd; d0 = n_done; rr_en = 1'b0;
      launch(1'b0, 3'd1, 9'h100, 12'd20);
      for (int i = 0; i < 40; i++) cycle();
      check("t2_stall_cmds", 64'(n_cmd - n0), 64'(DEPTH));
      check("t2_stall_busy", 64'(busy), 64'(1));
      rr_en = 1'b1;
      wait_done(d0, 300);
      check("t2_total_cmds", 64'(n_cmd - n0), 64'(20));

      // 3: write len 3 with random gaps on both handshakes
      cr_rand = 1'b1; wv_rand = 1'b1; d0 = n_done;
      run_burst(1'b1, 3'd4, 9'h0A0, 12'd3);
      for (int i = 0; i < 5; i++) cycle();
      check("t3_done_once", 64'(n_done - d0), 64'(1));
      run_burst(1'b1, 3'd0, 9'h1F0, 12'd6);
      cr_rand = 1'b0; wv_rand = 1'b0;

      // 4: zero-length descriptor, then start while busy
      n0 = n_cmd;
      launch(1'b0, 3'd1, 9'h020, 12'd0);
      cycle();
      cycle();
      check("t4_len0_busy", 64'(busy), 64'(1));
      check("t4_len0_done", 64'(done), 64'(1));
      cycle();
      check("t4_len0_nocmd", 64'(n_cmd - n0), 64'(0));
      d0 = n_done;
      launch(1'b0, 3'd1, 9'h040, 12'd4);
      cycle();
      launch(1'b1, 3'd3, 9'h080, 12'd5);
      cycle();
      wait_done(d0, 300);
      for (int i = 0; i < 4; i++) cycle();
      check("t4_ignored_cmds", 64'(n_cmd - n0), 64'(4));
      check("t4_done_once", 64'(n_done - d0), 64'(1));

      // 5: address wrap at the top of the bank
      acc_addr.delete(); acc_bank.delete();
      run_burst(1'b0, 3'd3, 9'h1FE, 12'd4);
`ifdef BANK_BURST_INTERLEAVE_EN
      ea = '{9'h1FE, 9'h1FE, 9'h1FF, 9'h1FF}; eb = '{3'd3, 3'd4, 3'd0, 3'd1};
`else
      ea = '{9'h1FE, 9'h1FF, 9'h000, 9'h001}; eb = '{3'd3, 3'd3, 3'd3, 3'd3};
`endif
      check("t5_ncmd", 64'(acc_addr.size()), 64'(4));
      for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
         check("t5_addr", 64'(acc_addr[i]), 64'(ea[i]));
         check("t5_bank", 64'(acc_bank[i]), 64'(eb[i]));
      end

      // 6: reset during DRAIN, then a fresh burst
      rr_en = 1'b0;
      launch(1'b0, 3'd2, 9'h0C0, 12'd8);
      for (int i = 0; i < 20; i++) cycle();
      check("t6_pre_busy", 64'(busy), 64'(1));
      check("t6_pre_rd_valid", 64'(rd_valid), 64'(1));
      rstn = 1'b0;
      #1;
      check("t6_rst_busy", 64'(busy), 64'(0));
      check("t6_rst_done", 64'(done), 64'(0));
      check("t6_rst_cmd_valid", 64'(cmd_valid), 64'(0));
      check("t6_rst_rd_valid", 64'(rd_valid), 64'(0));
      check("t6_rst_wr_ready", 64'(wr_ready), 64'(0));
      cmd_q.delete(); rd_q.delete(); rsp_q.delete(); wr_src.delete();
      hold = 1'b0; exp_done = 1'b0; cmd_left = 0; pop_left = 0;
      rsp_seq = exp_seq; rr_en = 1'b1;
      cycle();
      cycle();
      rstn = 1'b1;
      cycle();
      run_burst(1'b0, 3'd0, 9'h055, 12'd4);
      run_burst(1'b1, 3'd1, 9'h066, 12'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
